// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM data-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t WAIT  = 2'd2;
  localparam arb_state_t RESP  = 2'd3;

  typedef logic grant_t;
  localparam grant_t GNT_IF  = 1'b0;
  localparam grant_t GNT_MEM = 1'b1;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable 4-bit down-counter with zero flag; decrement saturates at zero.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF reads and MEM loads/stores onto one fixed-latency RAM port.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] LAT_LOAD    = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] STARVE_LOAD = CNT_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  grant_t            gnt_q, gnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic lat_load, lat_dec, lat_zero;
  logic starve_load, starve_dec, starved;
  logic mem_req, mem_wins;

  assign mem_req  = mem_rd | mem_wr;
  assign mem_wins = mem_req & ~(starved & if_req);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    lat_load    = 1'b0;
    lat_dec     = 1'b0;
    starve_load = 1'b0;
    starve_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_wins) begin
          state_d     = ISSUE;
          gnt_d       = GNT_MEM;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_wr;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          starve_dec  = if_req;
        end else if (if_req) begin
          state_d     = ISSUE;
          gnt_d       = GNT_IF;
          ram_en_d    = 1'b1;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
          starve_load = 1'b1;
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        lat_load = 1'b1;
      end
      WAIT: begin
        if (lat_zero) begin
          state_d = RESP;
          if (gnt_q == GNT_MEM) begin
            mem_ready_d = 1'b1;
            if (!ram_we_q) begin
              mem_rdata_d = ram_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = ram_rdata;
          end
        end else begin
          lat_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ram_we_q is held through WAIT so it still marks the granted access as a store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= (state_q == IDLE) ? ram_we_d : ram_we_q;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  mem_arb_lat_cnt #(
    .RST_VAL('0)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  // Counts down the MEM grants still allowed while IF waits; zero forces the next IF grant.
  mem_arb_lat_cnt #(
    .RST_VAL(STARVE_LOAD)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (starve_load),
    .load_val (STARVE_LOAD),
    .dec      (starve_dec),
    .zero     (starved)
  );

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q & ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
